core_axi_arb: RTL and testbench
===============================

CORE_AXI_ARB -- requirements
Module: core_axi_arb

Interface
REQ-001 Parameters: AXI_AWIDTH, default 4, address width on every port; AXI_DWIDTH, default 32, data width on every port; strobe width is AXI_DWIDTH/8.
REQ-002 CLK  in  1  single clock; all state is updated on its rising edge.
REQ-003 NRST  in  1  asynchronous, active-low reset.
REQ-004 M0_ARADDR/M0_ARVALID  in  AWIDTH/1  instruction-fetch master (M0) read address; M0_ARREADY  out  1.
REQ-005 M0_RDATA/M0_RRESP/M0_RVALID  out  DWIDTH/2/1  M0 read data; M0_RREADY  in  1.
REQ-006 M1_AWADDR/M1_AWVALID  in  AWIDTH/1  load/store master (M1) write address; M1_AWREADY  out  1.
REQ-007 M1_WDATA/M1_WSTRB/M1_WVALID  in  DWIDTH/DWIDTH/8/1  M1 write data; M1_WREADY  out  1.
REQ-008 M1_BRESP/M1_BVALID  out  2/1  M1 write response; M1_BREADY  in  1.
REQ-009 M1_ARADDR/M1_ARVALID  in  AWIDTH/1; M1_ARREADY  out  1; M1_RDATA/M1_RRESP/M1_RVALID  out  DWIDTH/2/1; M1_RREADY  in  1.
REQ-010 S_*  slave-side AXI-Lite port: the same five channels with mirrored directions, connected to shared data/instruction memory.

Function
REQ-011 The block SHALL serialize transactions: at most one transaction (one read or one write) is outstanding on S at any time.
REQ-012 FSM states: IDLE, RD0 (M0 read), RD1 (M1 read), WR1 (M1 write).
- No other states exist.
REQ-013 In IDLE, requests are sampled at the clock edge and the chosen state is entered on that edge.
- Requests: M0_ARVALID, M1_ARVALID, M1_AWVALID|M1_WVALID.
- Grant latency: S-side VALID asserts in the first cycle after the request is sampled.
REQ-014 When M1 has both a write and a read pending, the write SHALL win (WR1).
REQ-015 In RD0/RD1:
- S_ARADDR/S_ARVALID are driven from the granted master; S_ARVALID is gated off once the AR handshake completes (ar_done flag).
- The R channel is routed only to the granted master.
- On S_RVALID & granted RREADY, the FSM returns to IDLE and ar_done clears.
REQ-016 In WR1:
- AW and W are forwarded independently; each is gated off after its own handshake (aw_done and w_done flags).
- Handshake order between AW and W is arbitrary, including both in the same cycle.
- On S_BVALID & M1_BREADY, the FSM returns to IDLE and both flags clear.
REQ-017 Every READY/VALID toward a non-granted master SHALL be 0; every S_*VALID SHALL be 0 in IDLE.
REQ-018 Data, response and strobe fields SHALL pass through combinationally and unmodified; RRESP/BRESP are not interpreted.
REQ-019 IDLE to IDLE with no requests SHALL keep all outputs 0; back-to-back grants cost one IDLE cycle each.
REQ-020 A master that drops VALID before its handshake violates AXI; arbiter behaviour is then unspecified.

Reset
REQ-021 While NRST=0, the block SHALL immediately (asynchronously) hold:
- state=IDLE;
- ar_done, aw_done, w_done = 0;
- rr_last = M1;
- every VALID/READY output at 0.
REQ-022 Reset mid-transaction SHALL abandon the transaction with no response to the master; the first grant after release follows REQ-013.

Configuration
REQ-023 Macro ARB_RR_EN defined: when reads from M0 and M1 (with no M1 write pending) are sampled together, the master not equal to rr_last wins; rr_last updates on every grant.
REQ-024 ARB_RR_EN undefined: fixed priority, M1 always beats M0; rr_last logic is absent.

Verification
REQ-025 M0 reads 0x4 alone; S_ARREADY=1; S returns RDATA=0xDEADBEEF, RRESP=0 one cycle later -> M0_RDATA=0xDEADBEEF, M0_RVALID for one cycle, FSM back in IDLE; M1 sees no VALID/READY.
REQ-026 M1_AWVALID, M1_WVALID and M1_ARVALID all raised in the same cycle -> WR1 granted first; after the B handshake, an IDLE cycle, then RD1.
REQ-027 AW accepted at cycle n, W at cycle n+3 -> S_AWVALID low from n+1; S_WVALID stays high until n+3; one B returned to M1.
REQ-028 With ARB_RR_EN, M0 and M1 reads held continuously -> grants alternate M0,M1,M0,M1 (M0 first after reset). Without ARB_RR_EN -> M1 is granted every time; M0 only once M1 goes idle.
REQ-029 NRST pulsed low during RD1 after the AR handshake, before R -> all outputs 0 immediately; FSM in IDLE; a subsequent M0 read completes normally.

Source files
------------

// File: rtl/core_axi_arb.sv
// core_axi_arb
//   Two-master to one-slave AXI-Lite arbiter. M0 is the instruction-fetch
//   master and can only read. M1 is the load/store master and can read and
//   write. Only one transaction (one read or one write) is outstanding on the
//   slave port at any time.
//
//   An M1 write always beats any read. When both masters request a read
//   together:
//     ARB_RR_EN undefined : M1 wins (fixed priority).
//     ARB_RR_EN defined   : the master that was not granted last wins.
//                           r_rr_last holds the last grant and resets to M1.
//
//   Ports
//     i_clk, i_nrst        clock, asynchronous active-low reset
//     i_m0_ar*/o_m0_r*     M0 read address / read data channels
//     i_m1_aw*,i_m1_w*     M1 write address / write data channels
//     o_m1_b*              M1 write response channel
//     i_m1_ar*/o_m1_r*     M1 read address / read data channels
//     o_s_* / i_s_*        slave-side AXI-Lite port (all five channels)
//
//   Data, strobe and response fields pass through combinationally. Only the
//   VALID and READY signals are gated by the grant.
module core_axi_arb #(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32,
  localparam int SWIDTH    = AXI_DWIDTH/8
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  // M0 read
  input  logic [AXI_AWIDTH-1:0] i_m0_araddr,
  input  logic                  i_m0_arvalid,
  output logic                  o_m0_arready,
  output logic [AXI_DWIDTH-1:0] o_m0_rdata,
  output logic [1:0]            o_m0_rresp,
  output logic                  o_m0_rvalid,
  input  logic                  i_m0_rready,
  // M1 write
  input  logic [AXI_AWIDTH-1:0] i_m1_awaddr,
  input  logic                  i_m1_awvalid,
  output logic                  o_m1_awready,
  input  logic [AXI_DWIDTH-1:0] i_m1_wdata,
  input  logic [SWIDTH-1:0]     i_m1_wstrb,
  input  logic                  i_m1_wvalid,
  output logic                  o_m1_wready,
  output logic [1:0]            o_m1_bresp,
  output logic                  o_m1_bvalid,
  input  logic                  i_m1_bready,
  // M1 read
  input  logic [AXI_AWIDTH-1:0] i_m1_araddr,
  input  logic                  i_m1_arvalid,
  output logic                  o_m1_arready,
  output logic [AXI_DWIDTH-1:0] o_m1_rdata,
  output logic [1:0]            o_m1_rresp,
  output logic                  o_m1_rvalid,
  input  logic                  i_m1_rready,
  // slave port
  output logic [AXI_AWIDTH-1:0] o_s_awaddr,
  output logic                  o_s_awvalid,
  input  logic                  i_s_awready,
  output logic [AXI_DWIDTH-1:0] o_s_wdata,
  output logic [SWIDTH-1:0]     o_s_wstrb,
  output logic                  o_s_wvalid,
  input  logic                  i_s_wready,
  input  logic [1:0]            i_s_bresp,
  input  logic                  i_s_bvalid,
  output logic                  o_s_bready,
  output logic [AXI_AWIDTH-1:0] o_s_araddr,
  output logic                  o_s_arvalid,
  input  logic                  i_s_arready,
  input  logic [AXI_DWIDTH-1:0] i_s_rdata,
  input  logic [1:0]            i_s_rresp,
  input  logic                  i_s_rvalid,
  output logic                  o_s_rready
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

  state_t r_state, w_state_nxt;
  logic   r_ar_done, r_aw_done, r_w_done;
  logic   w_wr_req;

`ifdef ARB_RR_EN
  // 0 = M0 granted last, 1 = M1 granted last
  logic   r_rr_last;
`endif

  assign w_wr_req = i_m1_awvalid | i_m1_wvalid;

  // Pure pass-through fields. Only the handshake signals below are gated.
  assign o_s_awaddr = i_m1_awaddr;
  assign o_s_wdata  = i_m1_wdata;
  assign o_s_wstrb  = i_m1_wstrb;
  assign o_m1_bresp = i_s_bresp;
  assign o_m0_rdata = i_s_rdata;
  assign o_m0_rresp = i_s_rresp;
  assign o_m1_rdata = i_s_rdata;
  assign o_m1_rresp = i_s_rresp;
  assign o_s_araddr = (r_state == RD1) ? i_m1_araddr : i_m0_araddr;

  // State register and per-transaction handshake flags
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state   <= IDLE;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // The only way back to IDLE is the end of a transaction, so every
      // flag clears there. In IDLE itself no S-side VALID is high, so no
      // flag can set.
      if (w_state_nxt == IDLE) begin
        r_ar_done <= 1'b0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (o_s_arvalid & i_s_arready) r_ar_done <= 1'b1;
        if (o_s_awvalid & i_s_awready) r_aw_done <= 1'b1;
        if (o_s_wvalid  & i_s_wready)  r_w_done  <= 1'b1;
      end
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)
      r_rr_last <= 1'b1;
    else if (r_state == IDLE && w_state_nxt != IDLE)
      r_rr_last <= (w_state_nxt != RD0);
  end
`endif

  // Next-state logic and grant-gated handshakes
  always_comb begin
    w_state_nxt  = r_state;
    o_m0_arready = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m1_awready = 1'b0;
    o_m1_wready  = 1'b0;
    o_m1_bvalid  = 1'b0;
    o_m1_arready = 1'b0;
    o_m1_rvalid  = 1'b0;
    o_s_awvalid  = 1'b0;
    o_s_wvalid   = 1'b0;
    o_s_bready   = 1'b0;
    o_s_arvalid  = 1'b0;
    o_s_rready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wr_req)
          w_state_nxt = WR1;
        else if (i_m0_arvalid && i_m1_arvalid)
`ifdef ARB_RR_EN
          w_state_nxt = r_rr_last ? RD0 : RD1;
`else
          w_state_nxt = RD1;
`endif
        else if (i_m1_arvalid)
          w_state_nxt = RD1;
        else if (i_m0_arvalid)
          w_state_nxt = RD0;
      end
      RD0: begin
        o_s_arvalid  = i_m0_arvalid & ~r_ar_done;
        o_m0_arready = i_s_arready  & ~r_ar_done;
        o_m0_rvalid  = i_s_rvalid;
        o_s_rready   = i_m0_rready;
        if (i_s_rvalid && i_m0_rready) w_state_nxt = IDLE;
      end
      RD1: begin
        o_s_arvalid  = i_m1_arvalid & ~r_ar_done;
        o_m1_arready = i_s_arready  & ~r_ar_done;
        o_m1_rvalid  = i_s_rvalid;
        o_s_rready   = i_m1_rready;
        if (i_s_rvalid && i_m1_rready) w_state_nxt = IDLE;
      end
      WR1: begin
        // AW and W complete independently, in either order
        o_s_awvalid  = i_m1_awvalid & ~r_aw_done;
        o_m1_awready = i_s_awready  & ~r_aw_done;
        o_s_wvalid   = i_m1_wvalid  & ~r_w_done;
        o_m1_wready  = i_s_wready   & ~r_w_done;
        o_m1_bvalid  = i_s_bvalid;
        o_s_bready   = i_m1_bready;
        if (i_s_bvalid && i_m1_bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_axi_arb.sv
// Directed self-checking bench for core_axi_arb. All VALID/READY outputs are
// packed into one 12-bit vector and compared against hand-computed masks.
// The bench also covers the ARB_RR_EN build.
module tb_core_axi_arb;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk, nrst;
  logic [AW-1:0] m0_araddr, m1_awaddr, m1_araddr, s_awaddr, s_araddr;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [DW-1:0] m0_rdata, m1_wdata, m1_rdata, s_wdata, s_rdata;
  logic [1:0]    m0_rresp, m1_bresp, m1_rresp, s_bresp, s_rresp;
  logic          m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [3:0]    m1_wstrb, s_wstrb;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;

  core_axi_arb #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_m0_araddr(m0_araddr), .i_m0_arvalid(m0_arvalid), .o_m0_arready(m0_arready),
    .o_m0_rdata(m0_rdata), .o_m0_rresp(m0_rresp), .o_m0_rvalid(m0_rvalid), .i_m0_rready(m0_rready),
    .i_m1_awaddr(m1_awaddr), .i_m1_awvalid(m1_awvalid), .o_m1_awready(m1_awready),
    .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb), .i_m1_wvalid(m1_wvalid), .o_m1_wready(m1_wready),
    .o_m1_bresp(m1_bresp), .o_m1_bvalid(m1_bvalid), .i_m1_bready(m1_bready),
    .i_m1_araddr(m1_araddr), .i_m1_arvalid(m1_arvalid), .o_m1_arready(m1_arready),
    .o_m1_rdata(m1_rdata), .o_m1_rresp(m1_rresp), .o_m1_rvalid(m1_rvalid), .i_m1_rready(m1_rready),
    .o_s_awaddr(s_awaddr), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
    .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wvalid(s_wvalid), .i_s_wready(s_wready),
    .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready),
    .o_s_araddr(s_araddr), .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
    .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rvalid(s_rvalid), .o_s_rready(s_rready)
  );

  // handshake vector bit masks
  localparam logic [11:0] H_M0AR = 12'h800, H_M0R = 12'h400, H_M1AR = 12'h200,
                          H_M1R  = 12'h100, H_M1AW = 12'h080, H_M1W = 12'h040,
                          H_M1B  = 12'h020, H_SAR = 12'h010, H_SR  = 12'h008,
                          H_SAW  = 12'h004, H_SW  = 12'h002, H_SB  = 12'h001;

  int n_tests = 0, n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got running want finished");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] hs();
    return {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
            m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    m0_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0; m1_arvalid = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
    s_bresp = 0; s_rresp = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 0; #1;
    chk("reset_hs", hs(), 12'h000);
    tick(); tick();
    nrst = 1;
  endtask

  // Lone M0 read: IDLE, grant and AR, then R one cycle later.
  task automatic m0_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_arvalid = 1; m0_araddr = a; #1;
    chk({tag, "_idle"}, hs(), 12'h000);
    tick();
    s_arready = 1; #1;
    chk({tag, "_ar_hs"}, hs(), H_M0AR | H_SAR | H_SR);
    chk({tag, "_araddr"}, s_araddr, a);
    tick();
    m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = d; s_rresp = 0; #1;
    chk({tag, "_r_hs"}, hs(), H_M0R | H_SR);
    chk({tag, "_rdata"}, m0_rdata, d);
    chk({tag, "_rresp"}, m0_rresp, 2'd0);
    tick();
    s_rvalid = 0; #1;
    chk({tag, "_back_idle"}, hs(), 12'h000);
  endtask

  logic exp_m0[4];

  initial begin
    m0_araddr = 0; m1_awaddr = 0; m1_araddr = 0; m1_wdata = 0; m1_wstrb = 0;
    m0_rready = 1; m1_rready = 1; m1_bready = 1;
    do_reset();
    tick();
    #1 chk("idle_no_req", hs(), 12'h000);

    // Lone M0 read
    m0_read("m0rd", 4'h4, 32'hDEADBEEF);

    // Write and read raised together: the write is served first
    m1_awvalid = 1; m1_wvalid = 1; m1_arvalid = 1;
    m1_awaddr = 4'h8; m1_araddr = 4'hC; m1_wdata = 32'hCAFEF00D; m1_wstrb = 4'b0101; #1;
    chk("wr_rd_idle", hs(), 12'h000);
    tick();
    s_awready = 1; s_wready = 1; #1;
    chk("wr_first_hs", hs(), H_M1AW | H_M1W | H_SAW | H_SW | H_SB);
    chk("wr_awaddr", s_awaddr, 4'h8);
    chk("wr_wdata", s_wdata, 32'hCAFEF00D);
    chk("wr_wstrb", s_wstrb, 4'b0101);
    tick();
    m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = 2'b10; #1;
    chk("wr_b_hs", hs(), H_M1B | H_SB);
    chk("wr_bresp", m1_bresp, 2'b10);
    tick();
    s_bvalid = 0; #1;
    chk("wr_rd_gap_idle", hs(), 12'h000);
    tick();
    s_arready = 1; #1;
    chk("rd1_ar_hs", hs(), H_M1AR | H_SAR | H_SR);
    chk("rd1_araddr", s_araddr, 4'hC);
    tick();
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h12345678; s_rresp = 2'b01; #1;
    chk("rd1_r_hs", hs(), H_M1R | H_SR);
    chk("rd1_rdata", m1_rdata, 32'h12345678);
    chk("rd1_rresp", m1_rresp, 2'b01);
    tick();
    s_rvalid = 0; #1;
    chk("rd1_back_idle", hs(), 12'h000);

    // AW accepted at n, W at n+3. M1 keeps AWVALID up, so the gating is
    // visible on the slave side.
    m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 4'h2; #1;
    tick();
    s_awready = 1; #1;
    chk("aw_n_hs", hs(), H_M1AW | H_SAW | H_SW | H_SB);
    for (int k = 1; k <= 2; k++) begin
      tick(); #1;
      chk($sformatf("aw_gated_n%0d", k), hs(), H_SW | H_SB);
    end
    tick();
    s_wready = 1; #1;
    chk("w_n3_hs", hs(), H_SW | H_M1W | H_SB);
    tick();
    m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1; s_bresp = 0; #1;
    chk("aw_w_b_hs", hs(), H_M1B | H_SB);
    tick();
    s_bvalid = 0; #1;
    chk("aw_w_one_b", hs(), 12'h000);

    // Both masters hold read requests continuously
`ifdef ARB_RR_EN
    exp_m0[0] = 1; exp_m0[1] = 0; exp_m0[2] = 1; exp_m0[3] = 0;
`else
    exp_m0[0] = 0; exp_m0[1] = 0; exp_m0[2] = 0; exp_m0[3] = 1;
`endif
    do_reset();
    tick();
    m0_arvalid = 1; m1_arvalid = 1; m0_araddr = 4'h1; m1_araddr = 4'h3;
    for (int r = 0; r < 4; r++) begin
`ifndef ARB_RR_EN
      if (r == 3) m1_arvalid = 0;
`endif
      #1 chk($sformatf("arb%0d_idle", r), hs(), 12'h000);
      tick();
      s_arready = 1; #1;
      chk($sformatf("arb%0d_grant", r), hs(),
          exp_m0[r] ? (H_M0AR | H_SAR | H_SR) : (H_M1AR | H_SAR | H_SR));
      chk($sformatf("arb%0d_araddr", r), s_araddr, exp_m0[r] ? 4'h1 : 4'h3);
      tick();
      s_arready = 0; s_rvalid = 1; #1;
      chk($sformatf("arb%0d_r", r), hs(), exp_m0[r] ? (H_M0R | H_SR) : (H_M1R | H_SR));
      tick();
      s_rvalid = 0;
    end
    m0_arvalid = 0; m1_arvalid = 0;

    // Reset during RD1 after the AR handshake, before R
    do_reset();
    tick();
    m1_arvalid = 1; m1_araddr = 4'hA; #1;
    tick();
    #1 chk("rst_rd1_wait", hs(), H_SAR | H_SR);
    tick();
    s_arready = 1; #1;
    chk("rst_rd1_ar", hs(), H_M1AR | H_SAR | H_SR);
    tick();
    #1 chk("rst_rd1_ar_gated", hs(), H_SR);
    s_rvalid = 1;
    nrst = 0; #1;
    chk("rst_async_hs", hs(), 12'h000);
    tick();
    idle_inputs();
    nrst = 1; #1;
    chk("rst_release_idle", hs(), 12'h000);
    tick();
    m0_read("post_rst", 4'h6, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
